// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write-port controller.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin pick: grants the sole eligible requester, or the one that
// did not win last time when both are eligible. Purely combinational.
module rr_arb2 (
    input  logic [1:0] elig_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    always_comb begin
        gnt_o  = 2'b00;
        last_o = last_i;
        unique case (elig_i)
            2'b01: begin
                gnt_o  = 2'b01;
                last_o = 1'b0;
            end
            2'b10: begin
                gnt_o  = 2'b10;
                last_o = 1'b1;
            end
            2'b11: begin
                if (last_i) begin
                    gnt_o  = 2'b01;
                    last_o = 1'b0;
                end else begin
                    gnt_o  = 2'b10;
                    last_o = 1'b1;
                end
            end
            default: begin
                gnt_o  = 2'b00;
                last_o = last_i;
            end
        endcase
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the 8x32 register file: zero-fill after reset, then
// round-robin sharing of the write port between two requesters.
// Optional macro REG0_PROTECT_EN blocks requester writes to register 0.
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic              we,
    output logic              busy,
    output state_e            state_dbg
);

    localparam logic [ADDR_W:0] CLR_DONE = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;

    logic [1:0]        elig;
    logic [1:0]        arb_gnt;
    logic              arb_last;

    // A requester granted this cycle is masked so a request held one cycle too long cannot write twice.
    assign elig = {req1 & ~gnt1_q, req0 & ~gnt0_q};

    rr_arb2 u_rr_arb2 (
        .elig_i (elig),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .last_o (arb_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_cnt_q == CLR_DONE) begin
            state_d = ARB;
        end
    end

    always_comb begin
        clr_cnt_d = clr_cnt_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        unique case (state_q)
            CLEAR: begin
                if (clr_cnt_q == CLR_DONE) begin
                    busy_d = 1'b0;
                end else begin
                    we_d      = 1'b1;
                    waddr_d   = clr_cnt_q[ADDR_W-1:0];
                    wdata_d   = '0;
                    clr_cnt_d = clr_cnt_q + CLR_ONE;
                    busy_d    = 1'b1;
                end
            end
            ARB: begin
                last_d = arb_last;
                if (arb_gnt[0]) begin
                    gnt0_d  = 1'b1;
                    waddr_d = addr0;
                    wdata_d = data0;
`ifdef REG0_PROTECT_EN
                    we_d    = (addr0 != '0);
`else
                    we_d    = 1'b1;
`endif
                end else if (arb_gnt[1]) begin
                    gnt1_d  = 1'b1;
                    waddr_d = addr1;
                    wdata_d = data1;
`ifdef REG0_PROTECT_EN
                    we_d    = (addr1 != '0);
`else
                    we_d    = 1'b1;
`endif
                end
            end
            default: begin
                busy_d = busy_q;
            end
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign we        = we_q;
    assign wAddr     = waddr_q;
    assign wData     = wdata_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
